popcount_word_enumerator: RTL and testbench

//   Reverse direction of the PopCount8 datapath: given a target population count K, stream

---
 rtl/popcount_word_enumerator_if.sv | 27 ++
 rtl/popcount_word_enumerator.sv | 111 +++++++++++
 tb/tb_popcount_word_enumerator.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/popcount_word_enumerator_if.sv
// Handshake bundle for the popcount word enumerator: command side (K) and word stream side (O).
// The master drives commands and consumes words; the slave is the enumerator.
interface popcount_word_enumerator_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 4,
  parameter int SEQ_W = 7
);
  logic [CW-1:0]    K;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] O;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [SEQ_W-1:0] out_seq;
  logic             err;

  modport master (
    output K, cmd_valid, out_ready,
    input  cmd_ready, O, out_valid, out_last, out_seq, err
  );

  modport slave (
    input  K, cmd_valid, out_ready,
    output cmd_ready, O, out_valid, out_last, out_seq, err
  );
endinterface

// File: rtl/popcount_word_enumerator.sv
// Streams every WIDTH-bit word with popcount K in ascending order, one per accepted beat.
// Successor words come from Gosper's hack evaluated in WIDTH+1 bits.
module popcount_word_enumerator #(
  parameter int WIDTH = 8,
  parameter int CW    = 4,
  parameter int SEQ_W = 7
) (
  input  logic CLK,
  input  logic RESET,
  popcount_word_enumerator_if.slave bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;
  localparam int CTZ_W = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] WIDTH_K = CW'(WIDTH);

  logic [0:0]       state_reg;
  logic [WIDTH-1:0] word_reg;
  logic [WIDTH-1:0] top_reg;
  logic [SEQ_W-1:0] seq_reg;
  logic             valid_reg;
  logic             last_reg;
  logic             err_reg;

  logic [WIDTH:0]   word_ext;
  logic [WIDTH:0]   lsb_ext;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   tail_ext;
  logic [WIDTH:0]   next_ext;
  logic [CTZ_W-1:0] ctz;
  logic [WIDTH-1:0] init_word;
  logic [WIDTH-1:0] top_word;
  logic [CW-1:0]    top_start;
  logic             k_too_big;

  // Gosper successor: lowest set bit, ripple it up, refill the vacated ones at the bottom.
  assign word_ext = {1'b0, word_reg};
  assign lsb_ext  = word_ext & (-word_ext);
  assign sum_ext  = word_ext + lsb_ext;

  always_comb begin
    ctz = '0;
    for (int i = WIDTH; i >= 0; i--) begin
      if (lsb_ext[i]) ctz = CTZ_W'(i);
    end
  end

  assign tail_ext = ((word_ext ^ sum_ext) >> 2) >> ctz;
  assign next_ext = sum_ext | tail_ext;

  // First word has the K ones at the bottom; the final word has them at the top.
  assign top_start = WIDTH_K - bus.K;
  assign k_too_big = bus.K > WIDTH_K;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_masks
      assign init_word[gi] = CW'(gi) < bus.K;
      assign top_word[gi]  = CW'(gi) >= top_start;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      word_reg  <= '0;
      top_reg   <= '0;
      seq_reg   <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            if (k_too_big) begin
              err_reg <= 1'b1;
            end else begin
              state_reg <= ST_EMIT;
              word_reg  <= init_word;
              top_reg   <= top_word;
              seq_reg   <= '0;
              valid_reg <= 1'b1;
              last_reg  <= (bus.K == '0) || (bus.K == WIDTH_K);
            end
          end
        end
        default: begin
          if (bus.out_ready) begin
            if (last_reg) begin
              state_reg <= ST_IDLE;
              valid_reg <= 1'b0;
              last_reg  <= 1'b0;
            end else begin
              word_reg <= next_ext[WIDTH-1:0];
              seq_reg  <= seq_reg + SEQ_W'(1);
              last_reg <= next_ext == {1'b0, top_reg};
            end
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready = state_reg == ST_IDLE;
  assign bus.O         = word_reg;
  assign bus.out_seq   = seq_reg;
  assign bus.out_valid = valid_reg;
  assign bus.out_last  = last_reg;
  assign bus.err       = err_reg;
endmodule

// File: tb/tb_popcount_word_enumerator.sv
// Randomized scoreboard bench: the reference enumerates all 8-bit values and keeps those
// with the requested popcount; a negedge monitor pops and compares each accepted beat.
module tb_popcount_word_enumerator;
  localparam int WIDTH = 8;

  typedef struct {
    int word;
    int seq;
    int last;
  } beat_t;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  int   ready_mode;
  int   cur_k;
  int   beat_cnt;
  int   exp_n;
  beat_t exp_q[$];

  int   prev_stall;
  int   prev_word;
  int   prev_seq;
  int   prev_last;
  int   last_acc_word;

  popcount_word_enumerator_if #(.WIDTH(WIDTH), .CW(4), .SEQ_W(7)) bus ();

  popcount_word_enumerator #(.WIDTH(WIDTH), .CW(4), .SEQ_W(7)) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Consumer ready pattern: 0 = always ready, 1 = random, 2 = held low.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (bus.err) check("err_vs_valid", int'(bus.out_valid), 0);
      if (prev_stall != 0) begin
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_word", int'(bus.O), prev_word);
        check("stall_seq", int'(bus.out_seq), prev_seq);
        check("stall_last", int'(bus.out_last), prev_last);
      end
      prev_stall = 0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", int'(bus.O), -1);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("word", int'(bus.O), e.word);
            check("seq", int'(bus.out_seq), e.seq);
            check("last", int'(bus.out_last), e.last);
            check("popcount", $countones(bus.O), cur_k);
            if (e.seq > 0) check("ascending", int'(int'(bus.O) > last_acc_word), 1);
            last_acc_word = int'(bus.O);
          end
          beat_cnt++;
        end else begin
          prev_stall = 1;
          prev_word  = int'(bus.O);
          prev_seq   = int'(bus.out_seq);
          prev_last  = int'(bus.out_last);
        end
      end
    end
  end

  task automatic issue(input int k);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.cmd_ready) check("cmd_ready_timeout", 0, 1);
    exp_q.delete();
    exp_n = 0;
    if (k <= WIDTH) begin
      for (int v = 0; v < (1 << WIDTH); v++) begin
        if ($countones(v) == k) begin
          beat_t b;
          b.word = v; b.seq = exp_n; b.last = 0;
          exp_q.push_back(b);
          exp_n++;
        end
      end
      exp_q[exp_q.size() - 1].last = 1;
    end
    cur_k = k;
    beat_cnt = 0;
    bus.K = 4'(k);
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    if (k <= WIDTH) check("first_latency", int'(bus.out_valid), 1);
  endtask

  task automatic run_cmd(input int k);
    int n;
    issue(k);
    if (k > WIDTH) begin
      check("err_pulse", int'(bus.err), 1);
      check("err_no_valid", int'(bus.out_valid), 0);
      check("err_cmd_ready", int'(bus.cmd_ready), 1);
      repeat (3) begin
        @(posedge clk); #1;
        check("err_cleared", int'(bus.err), 0);
        check("err_idle_valid", int'(bus.out_valid), 0);
      end
    end else begin
      n = 0;
      while (!(exp_q.size() == 0 && !bus.out_valid) && n < 2000) begin
        @(posedge clk); #1; n++;
      end
      if (n >= 2000) check("stream_timeout", 0, 1);
      check("beat_count", beat_cnt, exp_n);
      check("done_cmd_ready", int'(bus.cmd_ready), 1);
    end
    $display("cmd K=%0d beats=%0d expected=%0d", k, beat_cnt, exp_n);
  endtask

  initial begin
    int n;
    pass_cnt = 0; total_cnt = 0; ready_mode = 0; prev_stall = 0;
    cur_k = 0; beat_cnt = 0; exp_n = 0; last_acc_word = 0;
    rst = 1'b1;
    bus.K = '0;
    bus.cmd_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_last", int'(bus.out_last), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_O", int'(bus.O), 0);
    check("rst_seq", int'(bus.out_seq), 0);
    rst = 1'b0;

    run_cmd(0);
    run_cmd(1);
    run_cmd(4);
    ready_mode = 1;
    run_cmd(3);
    ready_mode = 0;
    run_cmd(9);

    // Abort a K=5 stream with reset after 10 accepted beats.
    issue(5);
    n = 0;
    while (beat_cnt < 10 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (beat_cnt < 10) check("k5_timeout", beat_cnt, 10);
    ready_mode = 2;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    ready_mode = 0;
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_cmd_ready", int'(bus.cmd_ready), 1);
    check("abort_O", int'(bus.O), 0);
    check("abort_seq", int'(bus.out_seq), 0);
    check("abort_last", int'(bus.out_last), 0);
    $display("reset abort after %0d beats of K=5", beat_cnt);
    run_cmd(8);

    for (int i = 0; i < 6; i++) begin
      int k;
      k = $urandom_range(0, 10);
      ready_mode = $urandom_range(0, 1);
      run_cmd(k);
    end
    run_cmd(15);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
